// File: rtl/jtbubl_paldma.sv
// Palette loader: copies a 2^AW byte palette image from a byte-wide source
// memory into the palette RAM write port, writing only during vertical blank.
module jtbubl_paldma #(
    parameter int AW = 9,
    parameter int SW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [SW-1:0] src_base,
    input  logic          LVBL,
    output logic          busy,
    output logic          done,
    output logic          src_cs,
    output logic [SW-1:0] src_addr,
    input  logic [7:0]    src_data,
    input  logic          src_ok,
    output logic          pal_cs,
    output logic          cpu_rnw,
    output logic [AW-1:0] cpu_addr,
    output logic [7:0]    cpu_dout
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_VB = 3'd1,
        ST_FETCH   = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic [SW-1:0] base_r, base_s;
    logic [AW-1:0] cnt_r, cnt_s;
    logic [AW-1:0] cnt_inc_s;
    logic          busy_s, done_s, src_cs_s, pal_cs_s, cpu_rnw_s;
    logic [SW-1:0] src_addr_s;
    logic [AW-1:0] cpu_addr_s;
    logic [7:0]    cpu_dout_s;

    assign cnt_inc_s = cnt_r + {{(AW-1){1'b0}}, 1'b1};

    // Next-state and next-output computation; every output is registered below.
    always_comb begin
        state_s    = state_r;
        base_s     = base_r;
        cnt_s      = cnt_r;
        busy_s     = busy;
        done_s     = 1'b0;
        src_cs_s   = src_cs;
        src_addr_s = src_addr;
        pal_cs_s   = 1'b0;
        cpu_rnw_s  = 1'b1;
        cpu_addr_s = cpu_addr;
        cpu_dout_s = cpu_dout;
        case (state_r)
            ST_IDLE: begin
                busy_s   = 1'b0;
                src_cs_s = 1'b0;
                // busy can still be high for the done-pulse cycle; a start then is ignored
                if (start && !busy) begin
                    base_s = src_base;
                    cnt_s  = {AW{1'b0}};
                    busy_s = 1'b1;
                    if (!LVBL) begin
                        state_s    = ST_FETCH;
                        src_cs_s   = 1'b1;
                        src_addr_s = src_base;
                    end else begin
                        state_s = ST_WAIT_VB;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT_VB: begin
                if (!LVBL) begin
                    state_s    = ST_FETCH;
                    src_cs_s   = 1'b1;
                    src_addr_s = base_r + SW'(cnt_r);
                end else begin
                    src_cs_s = 1'b0;
                end
            end
            ST_FETCH: begin
                // blanking is not checked here: an in-flight byte always completes
                if (src_ok) begin
                    state_s    = ST_WRITE;
                    src_cs_s   = 1'b0;
                    pal_cs_s   = 1'b1;
                    cpu_rnw_s  = 1'b0;
                    cpu_addr_s = cnt_r;
                    cpu_dout_s = src_data;
                end else begin
                    src_cs_s = 1'b1;
                end
            end
            ST_WRITE: begin
                if (cnt_r == {AW{1'b1}}) begin
                    state_s = ST_DONE;
                end else begin
                    cnt_s = cnt_inc_s;
                    if (!LVBL) begin
                        state_s    = ST_FETCH;
                        src_cs_s   = 1'b1;
                        src_addr_s = base_r + SW'(cnt_inc_s);
                    end else begin
                        state_s = ST_WAIT_VB;
                    end
                end
            end
            ST_DONE: begin
                done_s  = 1'b1;
                busy_s  = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                state_s  = ST_IDLE;
                busy_s   = 1'b0;
                src_cs_s = 1'b0;
            end
        endcase
    end

    // State, transfer context and all output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            base_r   <= {SW{1'b0}};
            cnt_r    <= {AW{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            src_cs   <= 1'b0;
            src_addr <= {SW{1'b0}};
            pal_cs   <= 1'b0;
            cpu_rnw  <= 1'b1;
            cpu_addr <= {AW{1'b0}};
            cpu_dout <= 8'h00;
        end else begin
            state_r  <= state_s;
            base_r   <= base_s;
            cnt_r    <= cnt_s;
            busy     <= busy_s;
            done     <= done_s;
            src_cs   <= src_cs_s;
            src_addr <= src_addr_s;
            pal_cs   <= pal_cs_s;
            cpu_rnw  <= cpu_rnw_s;
            cpu_addr <= cpu_addr_s;
            cpu_dout <= cpu_dout_s;
        end
    end

endmodule

// File: tb/tb_jtbubl_paldma.sv
// Self-checking bench for jtbubl_paldma: random source memory, random wait
// states, and a palette model filled from observed writes.
module tb_jtbubl_paldma;

    logic        clk = 1'b0;
    logic        rst_n, start, LVBL, src_ok;
    logic [15:0] src_base, src_addr;
    logic [7:0]  src_data, cpu_dout;
    logic        busy, done, src_cs, pal_cs, cpu_rnw;
    logic [8:0]  cpu_addr;

    jtbubl_paldma #(.AW(9), .SW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_base(src_base), .LVBL(LVBL),
        .busy(busy), .done(done), .src_cs(src_cs), .src_addr(src_addr),
        .src_data(src_data), .src_ok(src_ok), .pal_cs(pal_cs), .cpu_rnw(cpu_rnw),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout)
    );

    always #5 clk = ~clk;

    int          vecs = 0, fails = 0;
    logic [7:0]  mem [65536];
    logic [7:0]  pal [512];
    int          wcount [512];
    logic [15:0] tb_base = 16'h0000;
    int          exp_idx = 0, done_cnt = 0, maxw = 0, cyc = 0;
    logic        lvbl_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Source memory responder with random latency
    initial begin
        int wleft;
        wleft = 0; src_ok = 1'b0; src_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!src_cs) begin
                src_ok = 1'b0;
                wleft  = int'($urandom_range(maxw, 0));
            end else if (wleft == 0) begin
                src_ok   = 1'b1;
                src_data = mem[src_addr];
            end else begin
                src_ok   = 1'b0;
                src_data = 8'($urandom);
                wleft--;
            end
        end
    end

    // LVBL as the DUT sees it at each active edge
    initial forever begin
        @(posedge clk);
        lvbl_seen = LVBL;
    end

    // Bus monitor: protocol checks and palette model
    initial begin
        logic        cs_prev, pal_prev;
        logic [15:0] addr_prev, a;
        cs_prev = 1'b0; pal_prev = 1'b0; addr_prev = 16'h0000;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                a = tb_base + exp_idx[15:0];
                if (src_cs) begin
                    if (!cs_prev) begin
                        chk("fetch_addr", src_addr, a);
                        chk("fetch_in_blank", lvbl_seen, 1'b0);
                    end else begin
                        chk("addr_hold", src_addr, addr_prev);
                    end
                end
                if (pal_cs) begin
                    chk("wr_rnw", cpu_rnw, 1'b0);
                    chk("wr_addr", cpu_addr, exp_idx);
                    chk("wr_data", cpu_dout, mem[a]);
                    chk("wr_single", pal_prev, 1'b0);
                    pal[cpu_addr] = cpu_dout;
                    wcount[cpu_addr]++;
                    exp_idx++;
                end else begin
                    chk("idle_rnw", cpu_rnw, 1'b1);
                end
                if (done) done_cnt++;
            end
            cs_prev = src_cs; pal_prev = pal_cs; addr_prev = src_addr;
        end
    end

    task automatic start_xfer(input logic [15:0] b);
        for (int i = 0; i < 512; i++) begin
            pal[i] = 'x;
            wcount[i] = 0;
        end
        done_cnt = 0; exp_idx = 0; tb_base = b;
        src_base = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; src_base = 16'($urandom);
    endtask

    task automatic wait_done(output int c);
        c = 0;
        while (done !== 1'b1 && c < 20000) begin
            @(posedge clk); #1;
            c++;
        end
        chk("done_seen", done, 1'b1);
    endtask

    task automatic wait_write(input int idx);
        int c;
        logic [8:0] ia;
        ia = idx[8:0];
        c = 0;
        while (!(pal_cs === 1'b1 && cpu_addr === ia) && c < 20000) begin
            @(posedge clk); #1;
            c++;
        end
        chk("reach_byte", cpu_addr, ia);
    endtask

    task automatic check_pal();
        logic [15:0] a;
        for (int i = 0; i < 512; i++) begin
            a = tb_base + i[15:0];
            chk("pal_data", pal[i], mem[a]);
            chk("pal_once", wcount[i], 1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_src_cs"}, src_cs, 1'b0);
        chk({tag, "_src_addr"}, src_addr, 16'h0000);
        chk({tag, "_pal_cs"}, pal_cs, 1'b0);
        chk({tag, "_rnw"}, cpu_rnw, 1'b1);
        chk({tag, "_cpu_addr"}, cpu_addr, 9'h000);
        chk({tag, "_cpu_dout"}, cpu_dout, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; src_base = 16'h0000; LVBL = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int k = 0; k < 512; k++) mem[16'h1000 + k] = k[7:0] ^ 8'h5A;
        repeat (3) @(posedge clk); #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic copy, no wait states: latency and contents
        maxw = 0;
        start_xfer(16'h1000);
        chk("t1_src_cs_next", src_cs, 1'b1);
        chk("t1_busy", busy, 1'b1);
        wait_done(cyc);
        chk("t1_latency", cyc, 1025);
        chk("t1_busy_at_done", busy, 1'b1);
        @(posedge clk); #1;
        chk("t1_busy_after", busy, 1'b0);
        chk("t1_done_pulse", done, 1'b0);
        chk("t1_done_count", done_cnt, 1);
        check_pal();

        // random wait states
        maxw = 7;
        start_xfer(16'($urandom));
        wait_done(cyc);
        @(posedge clk); #1;
        chk("t2_done_count", done_cnt, 1);
        check_pal();

        // blanking pause after byte 100
        maxw = 0;
        start_xfer(16'h3456);
        wait_write(100);
        LVBL = 1'b1;
        repeat (2000) @(posedge clk);
        #1;
        chk("t3_paused_writes", exp_idx, 101);
        chk("t3_paused_cs", src_cs, 1'b0);
        chk("t3_paused_busy", busy, 1'b1);
        LVBL = 1'b0;
        wait_done(cyc);
        @(posedge clk); #1;
        check_pal();

        // source address wrap
        maxw = 3;
        start_xfer(16'hFF80);
        wait_done(cyc);
        @(posedge clk); #1;
        chk("t4_done_count", done_cnt, 1);
        check_pal();

        // start while busy is ignored
        maxw = 1;
        start_xfer(16'h0400);
        wait_write(10);
        src_base = 16'h8000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t5_busy_kept", busy, 1'b1);
        wait_write(300);
        src_base = 16'hC000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc);
        repeat (20) @(posedge clk);
        #1;
        chk("t5_done_count", done_cnt, 1);
        chk("t5_idle", busy, 1'b0);
        check_pal();

        // asynchronous reset mid-transfer, then full re-copy
        maxw = 0;
        start_xfer(16'h2000);
        wait_write(200);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_xfer(16'h2000);
        wait_done(cyc);
        chk("t6_latency", cyc, 1025);
        @(posedge clk); #1;
        chk("t6_done_count", done_cnt, 1);
        check_pal();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
